// File: rtl/sb_dispatch_ctrl.sv
// Scoreboard dispatch controller: issues the scoreboard head, tracks in-flight latency, reports completion and flush.
// Optional performance counters are included when DISPATCH_PERF_EN is defined.
module sb_dispatch_ctrl #(
  parameter int NUM_SLOTS = 4,
  parameter int ALU_LAT   = 1,
  parameter int MUL_LAT   = 4,
  parameter int DIV_LAT   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] head_instr,
  input  logic [31:0] head_pc,
  input  logic        head_ready,
  input  logic        flush_req,
  input  logic [31:0] flush_instr,
  output logic        start_head,
  output logic        committing_instr,
  output logic [31:0] instr_to_finish,
  output logic        flushing_instr,
  output logic [31:0] instr_to_flush,
  output logic        exec_valid,
  output logic [31:0] exec_instr,
  output logic [31:0] exec_pc,
  output logic        busy
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0] perf_issue_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? ((DIV_LAT > ALU_LAT) ? DIV_LAT : ALU_LAT)
                                              : ((MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT);
  localparam int CW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int AW = $clog2(NUM_SLOTS + 1);
  localparam int IW = $clog2(NUM_SLOTS);

  logic [NUM_SLOTS-1:0] slot_valid;
  logic [31:0]          slot_instr [NUM_SLOTS];
  logic [31:0]          slot_pc    [NUM_SLOTS];
  logic [CW-1:0]        slot_cnt   [NUM_SLOTS];
  logic [AW-1:0]        slot_age   [NUM_SLOTS];

  logic                 free_any;
  logic [IW-1:0]        free_idx;
  logic                 dup_hit;
  logic                 match_any;
  logic [AW-1:0]        match_age;
  logic [NUM_SLOTS-1:0] squash;
  logic                 cand_any;
  logic [IW-1:0]        cand_idx;

  function automatic logic [CW-1:0] lat_m1(input logic [31:0] instr);
    logic is_m;
    is_m = (instr[6:0] == 7'b0110011) && (instr[31:25] == 7'b0000001);
    if (!is_m)          return CW'(ALU_LAT - 1);
    else if (!instr[14]) return CW'(MUL_LAT - 1);
    else                return CW'(DIV_LAT - 1);
  endfunction

  always_comb begin
    free_any  = 1'b0;
    free_idx  = '0;
    dup_hit   = 1'b0;
    match_any = 1'b0;
    match_age = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_valid[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
      if (slot_valid[i] && slot_instr[i] == head_instr) dup_hit = 1'b1;
      // Encodings in flight are unique, so at most one slot can match.
      if (slot_valid[i] && slot_instr[i] == flush_instr) begin
        match_any = 1'b1;
        match_age = slot_age[i];
      end
    end
  end

  always_comb begin
    squash   = '0;
    cand_any = 1'b0;
    cand_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      squash[i] = flush_req && match_any && slot_valid[i] && (slot_age[i] < match_age);
      if (slot_valid[i] && slot_cnt[i] == '0 && !squash[i]) begin
        cand_any = 1'b1;
        cand_idx = IW'(i);
      end
    end
  end

  assign start_head = head_ready && (head_instr != 32'd0) && free_any && !flush_req && !dup_hit;
  assign busy       = |slot_valid;

  always_ff @(posedge clock) begin
    if (!reset) begin
      slot_valid       <= '0;
      committing_instr <= 1'b0;
      instr_to_finish  <= '0;
      flushing_instr   <= 1'b0;
      instr_to_flush   <= '0;
      exec_valid       <= 1'b0;
      exec_instr       <= '0;
      exec_pc          <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_instr[i] <= '0;
        slot_pc[i]    <= '0;
        slot_cnt[i]   <= '0;
        slot_age[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (slot_valid[i]) begin
          if (squash[i] || (cand_any && cand_idx == IW'(i))) begin
            slot_valid[i] <= 1'b0;
          end else begin
            if (slot_cnt[i] != '0) slot_cnt[i] <= slot_cnt[i] - 1'b1;
            if (start_head && slot_age[i] < AW'(NUM_SLOTS)) slot_age[i] <= slot_age[i] + 1'b1;
          end
        end else if (start_head && free_idx == IW'(i)) begin
          slot_valid[i] <= 1'b1;
          slot_instr[i] <= head_instr;
          slot_pc[i]    <= head_pc;
          slot_cnt[i]   <= lat_m1(head_instr);
          slot_age[i]   <= '0;
        end
      end

      committing_instr <= cand_any;
      if (cand_any) instr_to_finish <= slot_instr[cand_idx];
      flushing_instr <= flush_req;
      if (flush_req) instr_to_flush <= flush_instr;
      exec_valid <= start_head;
      if (start_head) begin
        exec_instr <= head_instr;
        exec_pc    <= head_pc;
      end
    end
  end

`ifdef DISPATCH_PERF_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (start_head) perf_issue_cnt <= perf_issue_cnt + 1'b1;
      if (head_ready && head_instr != 32'd0 && !start_head) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (flush_req) perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sb_dispatch_ctrl.sv
// Directed bench for sb_dispatch_ctrl with default parameters (ALU 1, MUL 4, DIV 16, 4 slots).
module tb_sb_dispatch_ctrl;

  localparam logic [31:0] ADD  = 32'h00208033;
  localparam logic [31:0] ADD2 = 32'h00310233;
  localparam logic [31:0] MUL  = 32'h022081B3;
  localparam logic [31:0] MULA = 32'h02208233;
  localparam logic [31:0] MULB = 32'h022082B3;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] head_instr, head_pc, flush_instr;
  logic        head_ready, flush_req;
  logic        start_head, committing_instr, flushing_instr, exec_valid, busy;
  logic [31:0] instr_to_finish, instr_to_flush, exec_instr, exec_pc;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] divs [4];
  logic        seen;

  always #5 clock = ~clock;

  sb_dispatch_ctrl dut (
    .clock(clock), .reset(reset),
    .head_instr(head_instr), .head_pc(head_pc), .head_ready(head_ready),
    .flush_req(flush_req), .flush_instr(flush_instr),
    .start_head(start_head),
    .committing_instr(committing_instr), .instr_to_finish(instr_to_finish),
    .flushing_instr(flushing_instr), .instr_to_flush(instr_to_flush),
    .exec_valid(exec_valid), .exec_instr(exec_instr), .exec_pc(exec_pc),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    head_instr  = '0;
    head_pc     = '0;
    head_ready  = 1'b0;
    flush_req   = 1'b0;
    flush_instr = '0;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    head_instr = instr;
    head_pc    = pc;
    head_ready = 1'b1;
    #1;
  endtask

  task automatic drain;
    for (int k = 0; k < 60 && busy; k++) tick();
    chk("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    divs[0] = 32'h0220C1B3;
    divs[1] = 32'h0220C233;
    divs[2] = 32'h0220C2B3;
    divs[3] = 32'h0220C333;
    idle();
    reset = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_commit", {31'd0, committing_instr}, 32'd0);
    chk("rst_flush", {31'd0, flushing_instr}, 32'd0);
    chk("rst_exec_valid", {31'd0, exec_valid}, 32'd0);
    chk("rst_itf", instr_to_finish, 32'd0);
    chk("rst_exec_pc", exec_pc, 32'd0);
    reset = 1'b1;

    // single ALU op
    drive(ADD, 32'h100);
    chk("alu_start", {31'd0, start_head}, 32'd1);
    tick();
    idle();
    chk("alu_exec_valid", {31'd0, exec_valid}, 32'd1);
    chk("alu_exec_instr", exec_instr, ADD);
    chk("alu_exec_pc", exec_pc, 32'h100);
    chk("alu_busy", {31'd0, busy}, 32'd1);
    chk("alu_no_commit_yet", {31'd0, committing_instr}, 32'd0);
    tick();
    chk("alu_commit", {31'd0, committing_instr}, 32'd1);
    chk("alu_itf", instr_to_finish, ADD);
    chk("alu_exec_drop", {31'd0, exec_valid}, 32'd0);
    chk("alu_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("alu_commit_pulse", {31'd0, committing_instr}, 32'd0);

    // MUL then ALU: ALU overtakes
    drive(MUL, 32'h200);
    chk("mul_start", {31'd0, start_head}, 32'd1);
    tick();
    drive(ADD2, 32'h204);
    chk("add2_start", {31'd0, start_head}, 32'd1);
    tick();
    idle();
    chk("add2_exec_instr", exec_instr, ADD2);
    chk("mix_e1_commit", {31'd0, committing_instr}, 32'd0);
    tick();
    chk("mix_e2_commit", {31'd0, committing_instr}, 32'd1);
    chk("mix_e2_itf", instr_to_finish, ADD2);
    tick();
    chk("mix_e3_commit", {31'd0, committing_instr}, 32'd0);
    tick();
    chk("mix_e4_commit", {31'd0, committing_instr}, 32'd1);
    chk("mix_e4_itf", instr_to_finish, MUL);
    tick();
    chk("mix_e5_commit", {31'd0, committing_instr}, 32'd0);
    chk("mix_idle", {31'd0, busy}, 32'd0);

    // full table with 4 DIVs
    for (int k = 0; k < 4; k++) begin
      drive(divs[k], 32'h300 + 32'(4 * k));
      chk("div_start", {31'd0, start_head}, 32'd1);
      tick();
    end
    drive(ADD, 32'h340);
    for (int k = 3; k < 16; k++) begin
      chk("full_stall", {31'd0, start_head}, 32'd0);
      tick();
    end
    chk("full_commit", {31'd0, committing_instr}, 32'd1);
    chk("full_itf", instr_to_finish, divs[0]);
    chk("full_release", {31'd0, start_head}, 32'd1);
    tick();
    idle();
    chk("full_exec_valid", {31'd0, exec_valid}, 32'd1);
    chk("full_exec_instr", exec_instr, ADD);
    drain();

    // duplicate encoding held back
    drive(MUL, 32'h400);
    chk("dup_first", {31'd0, start_head}, 32'd1);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("dup_hold", {31'd0, start_head}, 32'd0);
      tick();
    end
    chk("dup_commit", {31'd0, committing_instr}, 32'd1);
    chk("dup_release", {31'd0, start_head}, 32'd1);
    tick();
    idle();
    chk("dup_exec_valid", {31'd0, exec_valid}, 32'd1);
    chk("dup_exec_instr", exec_instr, MUL);
    drain();

    // flush: older X kept, matching A kept, younger B squashed
    drive(MUL, 32'h500);
    tick();
    drive(MULA, 32'h504);
    tick();
    drive(MULB, 32'h508);
    tick();
    head_instr  = ADD;
    head_pc     = 32'h50C;
    flush_req   = 1'b1;
    flush_instr = MULA;
    #1;
    chk("flush_no_issue", {31'd0, start_head}, 32'd0);
    tick();
    idle();
    chk("flush_pulse", {31'd0, flushing_instr}, 32'd1);
    chk("flush_itf", instr_to_flush, MULA);
    chk("flush_e3_commit", {31'd0, committing_instr}, 32'd0);
    chk("flush_exec_valid", {31'd0, exec_valid}, 32'd0);
    tick();
    chk("flush_pulse_end", {31'd0, flushing_instr}, 32'd0);
    chk("flush_commit_x", {31'd0, committing_instr}, 32'd1);
    chk("flush_itf_x", instr_to_finish, MUL);
    tick();
    chk("flush_commit_a", {31'd0, committing_instr}, 32'd1);
    chk("flush_itf_a", instr_to_finish, MULA);
    tick();
    chk("flush_no_b", {31'd0, committing_instr}, 32'd0);
    chk("flush_idle", {31'd0, busy}, 32'd0);

    // non-matching flush coinciding with a completion
    drive(ADD, 32'h600);
    tick();
    idle();
    flush_req   = 1'b1;
    flush_instr = NOP;
    tick();
    flush_req = 1'b0;
    chk("nomatch_flush", {31'd0, flushing_instr}, 32'd1);
    chk("nomatch_itf", instr_to_flush, NOP);
    chk("nomatch_commit", {31'd0, committing_instr}, 32'd1);
    chk("nomatch_commit_itf", instr_to_finish, ADD);
    tick();
    chk("nomatch_idle", {31'd0, busy}, 32'd0);

    // reset with three slots in flight
    for (int k = 0; k < 3; k++) begin
      drive(divs[k], 32'h700 + 32'(4 * k));
      tick();
    end
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_exec_valid", {31'd0, exec_valid}, 32'd0);
    chk("mrst_commit", {31'd0, committing_instr}, 32'd0);
    chk("mrst_itf", instr_to_finish, 32'd0);
    chk("mrst_exec_instr", exec_instr, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      seen = seen | committing_instr;
    end
    chk("mrst_no_commit", {31'd0, seen}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
